// File: rtl/key_pkg.sv
// Shared key types and constants: debouncer FSM states, default filter
// length, and active-low key polarity used by debounce and decode stages.
package key_pkg;

    typedef enum logic [1:0] {
        UP,
        PRESS_WAIT,
        DOWN,
        REL_WAIT
    } kdb_state_t;

    // 20 ms of stable samples at 50 MHz
    localparam int DEF_CNT_MAX = 1_000_000;

    localparam logic KEY_PRESSED  = 1'b0;
    localparam logic KEY_RELEASED = 1'b1;

endpackage

// File: rtl/key_debounce_ch.sv
// One debounce channel: 2-flop synchroniser, UP/PRESS_WAIT/DOWN/REL_WAIT
// filter FSM with stable-sample counter, registered level and strobes.
// Ports: clk, rst (sync, active-high), key_in (raw, active-low),
//        key_out (debounced, active-low), key_press, key_release (1-cycle).
// Optional auto-repeat on key_press when KEY_DEBOUNCE_REPEAT_EN is defined.
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int CNT_MAX       = DEF_CNT_MAX,
    parameter int REPEAT_DELAY  = 25_000_000,
    parameter int REPEAT_PERIOD = 5_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic key_out,
    output logic key_press,
    output logic key_release
);

    localparam int CW = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

    if (CNT_MAX < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
        $error("key_debounce_ch: illegal parameter value");
    end

    logic sync1;
    logic sync2;

    kdb_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          out_q, out_d;
    logic          press_q, press_d;
    logic          rel_q, rel_d;
    logic          rep_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= KEY_RELEASED;
            sync2 <= KEY_RELEASED;
        end else begin
            sync1 <= key_in;
            sync2 <= sync1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        unique case (state_q)
            UP: begin
                if (sync2 == KEY_PRESSED) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (sync2 == KEY_RELEASED) begin
                    state_d = UP;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DOWN;
                    out_d   = KEY_PRESSED;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DOWN: begin
                if (sync2 == KEY_RELEASED) begin
                    state_d = REL_WAIT;
                    cnt_d   = '0;
                end
            end
            REL_WAIT: begin
                if (sync2 == KEY_PRESSED) begin
                    state_d = DOWN;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = UP;
                    out_d   = KEY_RELEASED;
                    rel_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = UP;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef KEY_DEBOUNCE_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = (RMAX > 2) ? $clog2(RMAX) : 1;
    localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0] rep_q, rep_d;
    logic          rep_ph_q, rep_ph_d;

    // rep_ph_q: first repeat already issued, now counting REPEAT_PERIOD
    always_comb begin
        rep_d    = '0;
        rep_ph_d = 1'b0;
        rep_hit  = 1'b0;
        if (state_q == DOWN && state_d == DOWN) begin
            rep_d    = rep_q + 1'b1;
            rep_ph_d = rep_ph_q;
            if (rep_q == (rep_ph_q ? PER_LAST : DLY_LAST)) begin
                rep_hit  = 1'b1;
                rep_d    = '0;
                rep_ph_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rep_q    <= '0;
            rep_ph_q <= 1'b0;
        end else begin
            rep_q    <= rep_d;
            rep_ph_q <= rep_ph_d;
        end
    end
`else
    assign rep_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= UP;
            cnt_q   <= '0;
            out_q   <= KEY_RELEASED;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            press_q <= press_d | rep_hit;
            rel_q   <= rel_d;
        end
    end

    assign key_out     = out_q;
    assign key_press   = press_q;
    assign key_release = rel_q;

endmodule

// File: rtl/key_debounce.sv
// N_KEYS-channel push-button debouncer feeding the key-decode stage.
// Ports: clk, rst (sync, active-high), key_in[N_KEYS] raw active-low,
//        key_out[N_KEYS] debounced active-low, key_press/key_release strobes.
// Auto-repeat enabled by defining KEY_DEBOUNCE_REPEAT_EN.
module key_debounce
    import key_pkg::*;
#(
    parameter int N_KEYS        = 4,
    parameter int CNT_MAX       = DEF_CNT_MAX,
    parameter int REPEAT_DELAY  = 25_000_000,
    parameter int REPEAT_PERIOD = 5_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_in,
    output logic [N_KEYS-1:0] key_out,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release
);

    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        key_debounce_ch #(
            .CNT_MAX       (CNT_MAX),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .key_in      (key_in[i]),
            .key_out     (key_out[i]),
            .key_press   (key_press[i]),
            .key_release (key_release[i])
        );
    end

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce with CNT_MAX=8: expected strobe events
// are queued by the stimulus thread and checked by a negedge monitor.
module tb_key_debounce;

    typedef struct {
        int         cyc;
        logic [3:0] ko;
        logic [3:0] kp;
        logic [3:0] kr;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] key_in = 4'b1111;
    logic [3:0] key_out;
    logic [3:0] key_press;
    logic [3:0] key_release;

    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t q[$];

    key_debounce #(
        .N_KEYS        (4),
        .CNT_MAX       (8),
        .REPEAT_DELAY  (20),
        .REPEAT_PERIOD (6)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_in      (key_in),
        .key_out     (key_out),
        .key_press   (key_press),
        .key_release (key_release)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every strobe must match the oldest expected event
    always @(negedge clk) begin
        if ((key_press | key_release) != 4'b0000) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe cyc=%0d press=%b release=%b",
                         cyc, key_press, key_release);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (e.cyc != cyc || e.ko != key_out ||
                    e.kp != key_press || e.kr != key_release) begin
                    errors++;
                    $display("FAIL strobe got cyc=%0d out=%b press=%b rel=%b want cyc=%0d out=%b press=%b rel=%b",
                             cyc, key_out, key_press, key_release,
                             e.cyc, e.ko, e.kp, e.kr);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_ev(input int c, input logic [3:0] ko,
                             input logic [3:0] kp, input logic [3:0] kr);
        exp_t e;
        e.cyc = c;
        e.ko  = ko;
        e.kp  = kp;
        e.kr  = kr;
        q.push_back(e);
    endtask

    task automatic chk_out(input string name, input logic [3:0] want);
        checks++;
        if (key_out !== want) begin
            errors++;
            $display("FAIL %s key_out=%b want=%b", name, key_out, want);
        end
    endtask

    initial begin
        int c;
        step(3);
        chk_out("reset_level", 4'b1111);
        rst = 1'b0;
        step(50);
        chk_out("idle_level", 4'b1111);

        // single press / release on key 0
        c = cyc;
        key_in = 4'b1110;
        expect_ev(c + 11, 4'b1110, 4'b0001, 4'b0000);
        step(9);
        chk_out("press_not_yet", 4'b1111);
        step(11);
        chk_out("press_level", 4'b1110);
        c = cyc;
        key_in = 4'b1111;
        expect_ev(c + 11, 4'b1111, 4'b0000, 4'b0001);
        step(20);
        chk_out("release_level", 4'b1111);

        // bouncing key 1: every low run is shorter than CNT_MAX
        key_in = 4'b1101;
        step(5);
        key_in = 4'b1111;
        step(2);
        key_in = 4'b1101;
        step(3);
        key_in = 4'b1111;
        step(20);
        chk_out("bounce_level", 4'b1111);

        // keys 3 and 2 together
        c = cyc;
        key_in = 4'b0011;
        expect_ev(c + 11, 4'b0011, 4'b1100, 4'b0000);
        step(20);
        chk_out("dual_level", 4'b0011);
        c = cyc;
        key_in = 4'b1111;
        expect_ev(c + 11, 4'b1111, 4'b0000, 4'b1100);
        step(20);
        chk_out("dual_rel_level", 4'b1111);

        // reset while key 0 is mid-count (cnt=5)
        key_in = 4'b1110;
        step(8);
        rst = 1'b1;
        step(1);
        chk_out("mid_reset_level", 4'b1111);
        c = cyc;
        rst = 1'b0;
        expect_ev(c + 11, 4'b1110, 4'b0001, 4'b0000);
        step(20);
        chk_out("post_reset_press", 4'b1110);

`ifdef KEY_DEBOUNCE_REPEAT_EN
        // key still held: repeats relative to accept edge c+11
        expect_ev(c + 31, 4'b1110, 4'b0001, 4'b0000);
        expect_ev(c + 37, 4'b1110, 4'b0001, 4'b0000);
        expect_ev(c + 43, 4'b1110, 4'b0001, 4'b0000);
        expect_ev(c + 49, 4'b1110, 4'b0001, 4'b0000);
        step(30);
        c = cyc;
`else
        c = cyc;
`endif
        key_in = 4'b1111;
        expect_ev(c + 11, 4'b1111, 4'b0000, 4'b0001);
        step(40);
        chk_out("final_level", 4'b1111);

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL missing_strobes pending=%0d want=0", q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
